// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, state
// encoding, default latencies and the countdown-width helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Count holds N-1 at most, so the widest latency sets the width.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. Results are
// computed at the accepting edge into staging registers and committed after
// a fixed latency so the pipeline sees a constant-timing unit.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDU_Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Read_Sel,
    output logic        Busy,
    output logic [31:0] Read_Data,
    output logic [31:0] Hi_Out,
    output logic [31:0] Lo_Out
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    mdu_state_e    r_state, w_state_n;
    logic [31:0]   r_hi, r_lo, w_hi_n, w_lo_n;
    logic [31:0]   r_res_hi, r_res_lo, w_res_hi_n, w_res_lo_n;
    logic [CW-1:0] r_count, w_count_n;
    logic          r_commit, w_commit_n;

    mdu_op_e       w_op;
    logic [63:0]   w_prod_s, w_prod_u;
    logic          w_a_neg, w_b_neg, w_b_zero, w_signed_div;
    logic [31:0]   w_div_a, w_div_b, w_q_mag, w_r_mag, w_quot, w_rem;

    assign w_op = mdu_op_e'(MDU_Op);

    // Low 64 bits of a 64x64 product of sign-extended operands are the signed product.
    assign w_prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    assign w_prod_u = {32'b0, SrcA} * {32'b0, SrcB};

    // Signed divide runs on magnitudes; 0x80000000 / -1 then falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    assign w_signed_div = (w_op == MDU_DIV);
    assign w_a_neg      = w_signed_div & SrcA[31];
    assign w_b_neg      = w_signed_div & SrcB[31];
    assign w_b_zero     = (SrcB == 32'd0);
    assign w_div_a      = w_a_neg ? (32'd0 - SrcA) : SrcA;
    assign w_div_b      = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - SrcB) : SrcB);
    assign w_q_mag      = w_div_a / w_div_b;
    assign w_r_mag      = w_div_a % w_div_b;
    assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_state_n  = r_state;
        w_hi_n     = r_hi;
        w_lo_n     = r_lo;
        w_res_hi_n = r_res_hi;
        w_res_lo_n = r_res_lo;
        w_count_n  = r_count;
        w_commit_n = r_commit;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    case (w_op)
                        MDU_MULT, MDU_MULTU: begin
                            w_res_hi_n = (w_op == MDU_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                            w_res_lo_n = (w_op == MDU_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                            w_count_n  = MULT_LOAD;
                            w_commit_n = 1'b1;
                            w_state_n  = S_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_res_hi_n = w_rem;
                            w_res_lo_n = w_quot;
                            w_count_n  = DIV_LOAD;
                            // Divide by zero still takes full latency but leaves HI/LO alone.
                            w_commit_n = ~w_b_zero;
                            w_state_n  = S_RUN;
                        end
                        MDU_MTHI: w_hi_n = SrcA;
                        MDU_MTLO: w_lo_n = SrcA;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (r_count == '0) begin
                    if (r_commit) begin
                        w_hi_n = r_res_hi;
                        w_lo_n = r_res_lo;
                    end
                    w_state_n = S_IDLE;
                end else begin
                    w_count_n = r_count - 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_count  <= '0;
            r_commit <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_hi     <= w_hi_n;
            r_lo     <= w_lo_n;
            r_res_hi <= w_res_hi_n;
            r_res_lo <= w_res_lo_n;
            r_count  <= w_count_n;
            r_commit <= w_commit_n;
        end
    end

    assign Busy      = (r_state == S_RUN);
    assign Hi_Out    = r_hi;
    assign Lo_Out    = r_lo;
    assign Read_Data = Read_Sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected HI/LO and busy length are queued when
// an op is issued and compared when the unit drops Busy.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDU_Op;
    logic [31:0] SrcA, SrcB;
    logic        Read_Sel;
    logic        Busy;
    logic [31:0] Read_Data, Hi_Out, Lo_Out;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDU_Op(MDU_Op),
        .SrcA(SrcA), .SrcB(SrcB), .Read_Sel(Read_Sel), .Busy(Busy),
        .Read_Data(Read_Data), .Hi_Out(Hi_Out), .Lo_Out(Lo_Out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] ph, input logic [31:0] pl);
        exp_t e;
        logic signed [63:0] ps;
        logic [63:0] pu;
        e.hi = ph; e.lo = pl; e.n = DC;
        case (op)
            MDU_MULT: begin
                ps = 64'($signed(a)) * 64'($signed(b));
                e.hi = ps[63:32]; e.lo = ps[31:0]; e.n = MC;
            end
            MDU_MULTU: begin
                pu = 64'(a) * 64'(b);
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.n = MC;
            end
            MDU_DIV: begin
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0; e.lo = 32'h8000_0000;
                end else begin
                    e.lo = 32'($signed(a) / $signed(b));
                    e.hi = 32'($signed(a) % $signed(b));
                end
            end
            MDU_DIVU: begin
                if (b != 0) begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic start_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input int n);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.n = n;
        sb.push_back(e);
        Start = 1'b1; MDU_Op = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        Start = 1'b0; MDU_Op = MDU_NONE;
    endtask

    task automatic mt(input mdu_op_e op, input logic [31:0] v);
        Start = 1'b1; MDU_Op = op; SrcA = v;
        @(posedge clk); #1;
        Start = 1'b0; MDU_Op = MDU_NONE;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Busy === 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; MDU_Op = MDU_NONE; SrcA = '0; SrcB = '0; Read_Sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
        checks++; if (Hi_Out !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", Hi_Out); end
        checks++; if (Lo_Out !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", Lo_Out); end
        checks++; if (Read_Data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", Read_Data); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        mdu_op_e     ops[2] = '{MDU_MULT, MDU_MULTU};
        logic [31:0] a[2]   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] b[2]   = '{32'd3,         32'hFFFF_FFFF};
        logic [31:0] eh[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] el[2]  = '{32'hFFFF_FFFA, 32'h0000_0001};
        int cyc;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            start_op(ops[i], a[i], b[i], eh[i], el[i], MC);
            wait_done(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== e.n) begin errors++; $display("FAIL mult%0d_busy got %0d want %0d", i, cyc, e.n); end
            checks++; if (Hi_Out !== e.hi) begin errors++; $display("FAIL mult%0d_hi got %h want %h", i, Hi_Out, e.hi); end
            checks++; if (Lo_Out !== e.lo) begin errors++; $display("FAIL mult%0d_lo got %h want %h", i, Lo_Out, e.lo); end
            Read_Sel = 1'b1; #1;
            checks++; if (Read_Data !== e.hi) begin errors++; $display("FAIL mult%0d_rd_hi got %h want %h", i, Read_Data, e.hi); end
            Read_Sel = 1'b0; #1;
        end
    endtask

    task automatic test_div;
        mdu_op_e     ops[4] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV};
        logic [31:0] a[4]   = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
        logic [31:0] b[4]   = '{32'd2,         32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] eh[4]  = '{32'hFFFF_FFFF, 32'd1, 32'h0,         32'd1};
        logic [31:0] el[4]  = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD};
        int cyc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            start_op(ops[i], a[i], b[i], eh[i], el[i], DC);
            wait_done(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== e.n) begin errors++; $display("FAIL div%0d_busy got %0d want %0d", i, cyc, e.n); end
            checks++; if (Hi_Out !== e.hi) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, Hi_Out, e.hi); end
            checks++; if (Lo_Out !== e.lo) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, Lo_Out, e.lo); end
            Read_Sel = 1'b0; #1;
            checks++; if (Read_Data !== e.lo) begin errors++; $display("FAIL div%0d_rd_lo got %h want %h", i, Read_Data, e.lo); end
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        exp_t e;
        mt(MDU_MTHI, 32'h1234_5678);
        Read_Sel = 1'b1; #1;
        checks++; if (Read_Data !== 32'h1234_5678) begin errors++; $display("FAIL mthi_rd got %h want 12345678", Read_Data); end
        mt(MDU_MTLO, 32'h0000_0055);
        start_op(MDU_DIVU, 32'd99, 32'd0, 32'h1234_5678, 32'h0000_0055, DC);
        wait_done(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== e.n) begin errors++; $display("FAIL div0_busy got %0d want %0d", cyc, e.n); end
        checks++; if (Hi_Out !== e.hi) begin errors++; $display("FAIL div0_hi got %h want %h", Hi_Out, e.hi); end
        checks++; if (Lo_Out !== e.lo) begin errors++; $display("FAIL div0_lo got %h want %h", Lo_Out, e.lo); end
        Read_Sel = 1'b0;
    endtask

    task automatic test_mt_while_busy;
        int cyc;
        exp_t e;
        start_op(MDU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, DC);
        repeat (3) @(posedge clk);
        #1;
        mt(MDU_MTLO, 32'h0000_00AA);
        wait_done(cyc);
        cyc += 4;
        e = sb.pop_front();
        checks++; if (cyc !== e.n) begin errors++; $display("FAIL mtbusy_busy got %0d want %0d", cyc, e.n); end
        checks++; if (Hi_Out !== e.hi) begin errors++; $display("FAIL mtbusy_hi got %h want %h", Hi_Out, e.hi); end
        checks++; if (Lo_Out !== e.lo) begin errors++; $display("FAIL mtbusy_lo got %h want %h", Lo_Out, e.lo); end
        mt(MDU_MTLO, 32'h0000_00AA);
        Read_Sel = 1'b0; #1;
        checks++; if (Read_Data !== 32'h0000_00AA) begin errors++; $display("FAIL mtlo_after_busy got %h want 000000aa", Read_Data); end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        exp_t e;
        mt(MDU_MTHI, 32'hDEAD_0001);
        mt(MDU_MTLO, 32'hBEEF_0002);
        Start = 1'b1; MDU_Op = MDU_DIVU; SrcA = 32'd100; SrcB = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0; MDU_Op = MDU_NONE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy got %0b want 0", Busy); end
        checks++; if (Hi_Out !== 32'h0) begin errors++; $display("FAIL rstrun_hi got %h want 0", Hi_Out); end
        checks++; if (Lo_Out !== 32'h0) begin errors++; $display("FAIL rstrun_lo got %h want 0", Lo_Out); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++; if ({Busy, Hi_Out, Lo_Out} !== 65'h0) begin
            errors++; $display("FAIL rstrun_nocommit got busy=%0b hi=%h lo=%h want all 0", Busy, Hi_Out, Lo_Out);
        end
        start_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MC);
        wait_done(cyc);
        e = sb.pop_front();
        checks++; if (cyc !== e.n) begin errors++; $display("FAIL rstmult_busy got %0d want %0d", cyc, e.n); end
        checks++; if ({Hi_Out, Lo_Out} !== {e.hi, e.lo}) begin
            errors++; $display("FAIL rstmult_hilo got %h_%h want %h_%h", Hi_Out, Lo_Out, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] mh, ml, a, b;
        mdu_op_e op;
        int cyc;
        exp_t m, e;
        mh = 32'h0BAD_F00D; ml = 32'h600D_CAFE;
        mt(MDU_MTHI, mh);
        mt(MDU_MTLO, ml);
        for (int i = 0; i < 10; i++) begin
            op = mdu_op_e'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (i == 3) begin op = MDU_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 6) begin op = MDU_DIV; a = $urandom; b = 32'd0; end
            m = model(op, a, b, mh, ml);
            mh = m.hi; ml = m.lo;
            start_op(op, a, b, m.hi, m.lo, m.n);
            wait_done(cyc);
            e = sb.pop_front();
            checks++; if (cyc !== e.n) begin errors++; $display("FAIL b2b%0d_busy op=%0d got %0d want %0d", i, op, cyc, e.n); end
            checks++; if ({Hi_Out, Lo_Out} !== {e.hi, e.lo}) begin
                errors++; $display("FAIL b2b%0d_hilo op=%0d a=%h b=%h got %h_%h want %h_%h",
                                   i, op, a, b, Hi_Out, Lo_Out, e.hi, e.lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mt_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
